disp_page_ctrl: RTL and testbench
=================================

DISP_PAGE_CTRL -- requirements
Module: disp_page_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, which sets the clk50MHz cycles per digit-scan tick (range 2..2^20).
REQ-002 The block SHALL have parameter HOLD, default 250, which sets the scan frames the result page is held before the block returns to the input page (range 1..255).
REQ-003 The block SHALL have port clk50MHz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port go, input, 1 bit: single-cycle start pulse from the debouncer.
REQ-006 The block SHALL have port done, input, 1 bit: level, high when the datapath operation has completed.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous return to the input page.
REQ-008 The block SHALL have port LEDsel, output, 2 bits: page select to the LED mux (00 inputs, 01 ALU result, 10 MS state, 11 unused).
REQ-009 The block SHALL have port an, output, 4 bits: active-low digit anodes, one-hot low.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in S_BUSY.
REQ-011 The block SHALL have port Done_out, output, 1 bit: LED, high while in S_RES.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 and wrap, asserting an internal tick for one cycle when its count equals DIV-1.
REQ-013 The 2-bit digit index SHALL advance by 1 on each tick and wrap 3->0, and each 3->0 wrap SHALL be one frame-end event.
REQ-014 The an output SHALL be registered, equal to ~(4'b0001 << digit), and update the cycle after the tick.
REQ-015 The FSM SHALL have states S_IN (LEDsel=00), S_BUSY (LEDsel=10) and S_RES (LEDsel=01), with all outputs registered.
REQ-016 On go in S_IN or S_RES, the FSM SHALL move to S_BUSY; LEDsel=10 and busy=1 SHALL be visible the following cycle.
REQ-017 In S_BUSY, the FSM SHALL ignore go, and done=1 SHALL move it to S_RES next cycle, setting Done_out=1.
REQ-018 In S_RES, an 8-bit frame counter SHALL clear on entry and increment on each frame end; when it reaches HOLD the FSM SHALL move to S_IN.
REQ-019 Priority SHALL be clear > done > go; clear in any state SHALL move the FSM to S_IN next cycle and zero the frame counter.
REQ-020 If go and the frame timeout coincide in S_RES, the FSM SHALL take go and move to S_BUSY.
REQ-021 done held high on entry to S_IN SHALL have no effect; only S_BUSY samples done.
REQ-022 The prescaler and digit scan SHALL run free in every state and SHALL NOT be reset by clear or by state changes.

Reset
REQ-023 rst=1 SHALL immediately force: state S_IN, LEDsel=00, an=4'b1110, digit=0, prescaler=0, frame counter=0, busy=0, Done_out=0, blank=0.
REQ-024 A reset asserted mid-operation SHALL abandon S_BUSY or S_RES with no pending transition retained after release.

Configuration
REQ-025 When macro DISP_BLINK_EN is defined, an internal blank flag SHALL toggle on each frame end while in S_BUSY and clear on leaving S_BUSY; while blank=1, an SHALL be 4'b1111.
REQ-026 When DISP_BLINK_EN is undefined, blank SHALL be constant 0 and an SHALL follow REQ-014 in all states.

Verification (DIV=4, HOLD=2)
REQ-027 A bench SHALL check scan: after rst release, run 32 cycles -> an sequence 1110,1101,1011,0111,1110 with a change every 4 cycles.
REQ-028 A bench SHALL check the nominal flow: go pulse at cycle 10 -> LEDsel=10, busy=1 at 11; done=1 at 20 -> LEDsel=01, Done_out=1 at 21; after 2 frame ends -> LEDsel=00 the next cycle.
REQ-029 A bench SHALL check precedence: go and done high together in S_BUSY -> S_RES; clear, go and done high together in S_BUSY -> S_IN, busy=0.
REQ-030 A bench SHALL check restart: go during S_RES -> S_BUSY next cycle, Done_out=0, and the frame counter restarts at 0 on the next S_RES entry.
REQ-031 A bench SHALL check reset mid-op: rst pulse during S_BUSY with the prescaler at 2 -> outputs at reset values within the same cycle, an=1110, and the first tick 4 cycles after release.
REQ-032 A bench SHALL check blink with DISP_BLINK_EN defined: in S_BUSY an alternates between all-1111 frames and scanning frames; undefined -> an never 1111.

Source files
------------

// File: rtl/disp_page_ctrl.sv
// Display page controller: free-running digit scan plus input/busy/result page FSM.
// Optional blanking of the display in S_BUSY is enabled by defining DISP_BLINK_EN.
module disp_page_ctrl #(
   parameter int unsigned DIV  = 50000,
   parameter int unsigned HOLD = 250
) (
   input  logic       clk50MHz,
   input  logic       rst,
   input  logic       go,
   input  logic       done,
   input  logic       clear,
   output logic [1:0] LEDsel,
   output logic [3:0] an,
   output logic       busy,
   output logic       Done_out
);

   localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IN   = 2'd0,
      S_BUSY = 2'd1,
      S_RES  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] presc;
   logic [1:0]    digit;
   logic [1:0]    digit_nxt;
   logic [7:0]    frame_cnt;
   logic          blank;
   logic          blank_nxt;
   logic          tick;
   logic          frame_end;
   logic          timeout;

   assign tick      = (presc == PW'(DIV - 1));
   assign frame_end = tick && (digit == 2'd3);
   assign digit_nxt = tick ? digit + 2'd1 : digit;
   assign timeout   = frame_end && (frame_cnt == 8'(HOLD - 1));

   // Next page; clear beats done beats go, and go beats the result-page timeout.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IN:    if (go) state_nxt = S_BUSY;
         S_BUSY:  if (done) state_nxt = S_RES;
         S_RES: begin
            if (go)           state_nxt = S_BUSY;
            else if (timeout) state_nxt = S_IN;
         end
         default: state_nxt = S_IN;
      endcase
      if (clear) state_nxt = S_IN;
   end

`ifdef DISP_BLINK_EN
   // Blank every other frame while busy; always drop blanking when leaving S_BUSY.
   always_comb begin
      blank_nxt = 1'b0;
      if (state_nxt == S_BUSY)
         blank_nxt = (state == S_BUSY && frame_end) ? ~blank : blank;
   end
`else
   assign blank_nxt = 1'b0;
`endif

   // Prescaler and digit scan run free; only rst touches them.
   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         presc <= '0;
         digit <= 2'd0;
         blank <= 1'b0;
         an    <= 4'b1110;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         digit <= digit_nxt;
         blank <= blank_nxt;
         an    <= blank_nxt ? 4'b1111 : ~(4'b0001 << digit_nxt);
      end
   end

   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         state     <= S_IN;
         LEDsel    <= 2'b00;
         busy      <= 1'b0;
         Done_out  <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt == S_BUSY);
         Done_out <= (state_nxt == S_RES);
         unique case (state_nxt)
            S_BUSY:  LEDsel <= 2'b10;
            S_RES:   LEDsel <= 2'b01;
            default: LEDsel <= 2'b00;
         endcase
         if (state_nxt != S_RES || state != S_RES)
            frame_cnt <= 8'd0;
         else if (frame_end)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Directed bench for disp_page_ctrl with DIV=4, HOLD=2; k counts clock edges since reset release.
module tb_disp_page_ctrl;

   logic       clk50MHz;
   logic       rst;
   logic       go;
   logic       done;
   logic       clear;
   logic [1:0] LEDsel;
   logic [3:0] an;
   logic       busy;
   logic       Done_out;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   disp_page_ctrl #(.DIV(4), .HOLD(2)) dut (
      .clk50MHz (clk50MHz),
      .rst      (rst),
      .go       (go),
      .done     (done),
      .clear    (clear),
      .LEDsel   (LEDsel),
      .an       (an),
      .busy     (busy),
      .Done_out (Done_out)
   );

   initial clk50MHz = 1'b0;
   always #5 clk50MHz = ~clk50MHz;

   // Expected anode pattern k edges after reset release (a tick every 4 edges).
   function automatic logic [3:0] scan_an(input int kk);
      logic [1:0] d;
      d = 2'((kk / 4) % 4);
      return ~(4'b0001 << d);
   endfunction

   task automatic cycle();
      @(posedge clk50MHz);
      #1;
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) cycle();
   endtask

   task automatic do_reset();
      go = 1'b0; done = 1'b0; clear = 1'b0;
      rst = 1'b1;
      @(posedge clk50MHz);
      #1;
      rst = 1'b0;
      k = 0;
   endtask

   task automatic check_page(input string name, input logic [1:0] sel, input logic b, input logic d);
      checks++;
      if (LEDsel !== sel || busy !== b || Done_out !== d) begin
         errors++;
         $display("FAIL %s k=%0d: LEDsel/busy/Done_out got %b/%b/%b want %b/%b/%b",
                  name, k, LEDsel, busy, Done_out, sel, b, d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b0; done = 1'b0; clear = 1'b0;
      @(posedge clk50MHz);
      #1;
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL reset_an: got %b want 1110", an);
      end
      check_page("reset_page", 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      k = 0;
   endtask

   task automatic test_scan();
      for (int i = 1; i <= 32; i++) begin
         cycle();
         checks++;
         if (an !== scan_an(k)) begin
            errors++;
            $display("FAIL scan k=%0d: an got %b want %b", k, an, scan_an(k));
         end
      end
   endtask

   task automatic test_nominal();
      do_reset();
      run_to(9);
      check_page("nom_idle", 2'b00, 1'b0, 1'b0);
      go = 1'b1;
      cycle();
      go = 1'b0;
      check_page("nom_busy", 2'b10, 1'b1, 1'b0);
      run_to(19);
      check_page("nom_still_busy", 2'b10, 1'b1, 1'b0);
      done = 1'b1;
      cycle();
      done = 1'b0;
      check_page("nom_res", 2'b01, 1'b0, 1'b1);
      run_to(32);
      check_page("nom_res_frame1", 2'b01, 1'b0, 1'b1);
      done = 1'b1;
      run_to(47);
      check_page("nom_res_hold", 2'b01, 1'b0, 1'b1);
      cycle();
      check_page("nom_timeout", 2'b00, 1'b0, 1'b0);
      run_to(52);
      done = 1'b0;
      check_page("nom_done_in_idle", 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_precedence();
      do_reset();
      go = 1'b1;
      cycle();
      check_page("prec_busy", 2'b10, 1'b1, 1'b0);
      done = 1'b1;
      cycle();
      go = 1'b0; done = 1'b0;
      check_page("prec_done_over_go", 2'b01, 1'b0, 1'b1);
      go = 1'b1;
      cycle();
      check_page("prec_go_from_res", 2'b10, 1'b1, 1'b0);
      cycle();
      check_page("prec_go_ignored_busy", 2'b10, 1'b1, 1'b0);
      clear = 1'b1; done = 1'b1;
      cycle();
      clear = 1'b0; done = 1'b0; go = 1'b0;
      check_page("prec_clear_wins", 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_restart();
      do_reset();
      go = 1'b1;
      cycle();
      go = 1'b0; done = 1'b1;
      cycle();
      done = 1'b0;
      check_page("rst_res1", 2'b01, 1'b0, 1'b1);
      run_to(20);
      go = 1'b1;
      cycle();
      go = 1'b0;
      check_page("restart_busy", 2'b10, 1'b1, 1'b0);
      done = 1'b1;
      cycle();
      done = 1'b0;
      check_page("restart_res2", 2'b01, 1'b0, 1'b1);
      run_to(32);
      check_page("restart_cnt_cleared", 2'b01, 1'b0, 1'b1);
      run_to(48);
      check_page("restart_timeout", 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midop();
      do_reset();
      go = 1'b1;
      cycle();
      go = 1'b0;
      run_to(6);
      check_page("midop_busy", 2'b10, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check_page("midop_async", 2'b00, 1'b0, 1'b0);
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL midop_an: got %b want 1110", an);
      end
      #2;
      rst = 1'b0;
      k = 0;
      run_to(3);
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL midop_pre_tick: got %b want 1110", an);
      end
      cycle();
      checks++;
      if (an !== 4'b1101) begin
         errors++;
         $display("FAIL midop_first_tick: got %b want 1101", an);
      end
      check_page("midop_no_pending", 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_blink();
      logic [3:0] exp_an;
      do_reset();
      go = 1'b1;
      cycle();
      go = 1'b0;
      for (int i = 2; i <= 40; i++) begin
         cycle();
`ifdef DISP_BLINK_EN
         exp_an = (((k / 16) % 2) == 1) ? 4'b1111 : scan_an(k);
`else
         exp_an = scan_an(k);
`endif
         checks++;
         if (an !== exp_an) begin
            errors++;
            $display("FAIL blink k=%0d: an got %b want %b", k, an, exp_an);
         end
      end
      run_to(52);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      checks++;
      if (an !== scan_an(k)) begin
         errors++;
         $display("FAIL blink_exit k=%0d: an got %b want %b", k, an, scan_an(k));
      end
      check_page("blink_exit_page", 2'b00, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_scan();
      test_nominal();
      test_precedence();
      test_restart();
      test_reset_midop();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
